// File: rtl/ntt_pkg.sv
// Shared constants and state encoding for the NTT job scheduler and its bench.
package ntt_pkg;
  localparam int Q      = 97;
  localparam int COEF_W = 7;
  localparam int N_COEF = 16;
  localparam int N_REQ  = 2;
  localparam int RES_W  = N_COEF * COEF_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_CHECK   = 3'd3,
    S_RELEASE = 3'd4
  } sched_state_e;
endpackage

// File: rtl/ntt_job_sched_if.sv
// Signal bundle between the two requesters, the scheduler and the shared NTT engine.
interface ntt_job_sched_if;
  import ntt_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] job_done;
  logic             job_err;
  logic             busy;
  logic             eng_start;
  logic             eng_done;
  logic [RES_W-1:0] eng_result;
  logic [RES_W-1:0] res_data;
  logic             res_owner;

  // Scheduler side.
  modport slave (
    input  req, eng_done, eng_result,
    output gnt, job_done, job_err, busy, eng_start, res_data, res_owner
  );

  // Requester/engine side.
  modport master (
    output req, eng_done, eng_result,
    input  gnt, job_done, job_err, busy, eng_start, res_data, res_owner
  );
endinterface

// File: rtl/ntt_range_check.sv
// Flags when any of the 16 packed coefficients is not a valid residue (>= Q).
module ntt_range_check
  import ntt_pkg::*;
(
  input  logic [RES_W-1:0] coef_i,
  output logic             any_ge_q
);

  // All 16 unsigned comparators evaluated in parallel and OR-reduced.
  always_comb begin
    any_ge_q = 1'b0;
    for (int i = 0; i < N_COEF; i++) begin
      if (coef_i[i*COEF_W +: COEF_W] >= COEF_W'(Q)) any_ge_q = 1'b1;
    end
  end

endmodule

// File: rtl/ntt_job_sched.sv
// Round-robin scheduler sharing one NTT engine between two requesters, with a
// start pulse, a done watchdog, result latching and range checking.
module ntt_job_sched
  import ntt_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst,
  ntt_job_sched_if.slave bus
);

  // Watchdog value at which WAIT gives up on the engine.
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  sched_state_e     state_q, state_d;
  logic [15:0]      wd_q, wd_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic             tmo_q, tmo_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             res_own_q, res_own_d;
  logic             range_err;

  ntt_range_check u_range (
    .coef_i   (res_q),
    .any_ge_q (range_err)
  );

  // Next-state and registered-output decisions for the job sequence.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    last_d    = last_q;
    owner_d   = owner_q;
    tmo_d     = tmo_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = err_q;
    start_d   = 1'b0;
    res_d     = res_q;
    res_own_d = res_own_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req != '0) begin
          // Contention goes to whichever requester was not served last.
          owner_d = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          gnt_d   = owner_d ? 2'b10 : 2'b01;
          state_d = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        wd_d    = '0;
        tmo_d   = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the expiry cycle still counts as success.
        if (bus.eng_done) begin
          res_d     = bus.eng_result;
          res_own_d = owner_q;
          state_d   = S_CHECK;
        end else if (wd_q == WD_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_CHECK;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_CHECK: begin
        err_d   = tmo_q | range_err;
        done_d  = owner_q ? 2'b10 : 2'b01;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!bus.req[owner_q]) begin
          gnt_d   = '0;
          last_d  = owner_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset returns every output to zero at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wd_q      <= '0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      tmo_q     <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      res_q     <= '0;
      res_own_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      tmo_q     <= tmo_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      start_q   <= start_d;
      res_q     <= res_d;
      res_own_q <= res_own_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.job_done  = done_q;
  assign bus.job_err   = err_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.eng_start = start_q;
  assign bus.res_data  = res_q;
  assign bus.res_owner = res_own_q;

endmodule

// File: tb/tb_ntt_job_sched.sv
// Randomized bench for ntt_job_sched: a job-level timeline model predicts grants,
// start pulse, watchdog outcome, latched results and completion status.
`timescale 1ns/1ps
module tb_ntt_job_sched;
  import ntt_pkg::*;

  localparam int TO_A = 4096;
  localparam int TO_B = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             sel;
  logic [N_REQ-1:0] req_drv;
  logic             eng_done_drv;
  logic [RES_W-1:0] eng_result_drv;

  ntt_job_sched_if ifa();
  ntt_job_sched_if ifb();

  ntt_job_sched #(.TIMEOUT(TO_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  ntt_job_sched #(.TIMEOUT(TO_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  always #5 clk = ~clk;

  assign ifa.req        = sel ? '0 : req_drv;
  assign ifb.req        = sel ? req_drv : '0;
  assign ifa.eng_done   = sel ? 1'b0 : eng_done_drv;
  assign ifb.eng_done   = sel ? eng_done_drv : 1'b0;
  assign ifa.eng_result = eng_result_drv;
  assign ifb.eng_result = eng_result_drv;

  logic [1:0]       o_gnt, o_job_done;
  logic             o_job_err, o_busy, o_eng_start, o_res_owner;
  logic [RES_W-1:0] o_res_data;
  assign o_gnt       = sel ? ifb.gnt       : ifa.gnt;
  assign o_job_done  = sel ? ifb.job_done  : ifa.job_done;
  assign o_job_err   = sel ? ifb.job_err   : ifa.job_err;
  assign o_busy      = sel ? ifb.busy      : ifa.busy;
  assign o_eng_start = sel ? ifb.eng_start : ifa.eng_start;
  assign o_res_owner = sel ? ifb.res_owner : ifa.res_owner;
  assign o_res_data  = sel ? ifb.res_data  : ifa.res_data;

  int vectors = 0;
  int errs    = 0;
  int to_cur;
  int last_m;
  int own_m;
  logic [RES_W-1:0] res_m;
  int own_o;
  int rr_exp [4] = '{0, 1, 0, 1};
  logic [RES_W-1:0] d1, d3;
  bit ed;

  task automatic chk(input string tag, input logic [RES_W-1:0] obs, input logic [RES_W-1:0] want);
    vectors++;
    if (obs !== want) begin
      errs++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic bit any_ge(input logic [RES_W-1:0] d);
    for (int i = 0; i < N_COEF; i++)
      if (d[i*COEF_W +: COEF_W] >= Q) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int pick(input logic [1:0] r, input int last);
    if (r == 2'b11) return 1 - last;
    return r[1] ? 1 : 0;
  endfunction

  function automatic logic [RES_W-1:0] fill(input int v);
    logic [RES_W-1:0] d;
    for (int i = 0; i < N_COEF; i++) d[i*COEF_W +: COEF_W] = COEF_W'(v);
    return d;
  endfunction

  function automatic logic [RES_W-1:0] rand_coefs(input bit force_bad);
    logic [RES_W-1:0] d;
    int bad;
    for (int i = 0; i < N_COEF; i++) d[i*COEF_W +: COEF_W] = COEF_W'($urandom_range(0, Q - 1));
    if (force_bad) begin
      bad = $urandom_range(0, N_COEF - 1);
      d[bad*COEF_W +: COEF_W] = COEF_W'($urandom_range(Q, (1 << COEF_W) - 1));
    end
    return d;
  endfunction

  function automatic logic [RES_W-1:0] coef7(input int v);
    logic [RES_W-1:0] d;
    d = '0;
    d[7*COEF_W +: COEF_W] = COEF_W'(v);
    return d;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},   o_gnt, 0);
    chk({tag, "_done"},  o_job_done, 0);
    chk({tag, "_err"},   o_job_err, 0);
    chk({tag, "_busy"},  o_busy, 0);
    chk({tag, "_start"}, o_eng_start, 0);
    chk({tag, "_res"},   o_res_data, 0);
    chk({tag, "_own"},   o_res_owner, 0);
  endtask

  task automatic model_reset();
    last_m = 1;
    own_m  = 0;
    res_m  = '0;
  endtask

  task automatic do_reset();
    req_drv      = '0;
    eng_done_drv = 1'b0;
    rst          = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    model_reset();
    cyc();
  endtask

  // One job, entered on the negedge of the cycle in which IDLE sees req_drv.
  // lat: WAIT cycles before eng_done (negative means the engine never answers).
  task automatic do_job(input int lat, input logic [RES_W-1:0] data, input bit done_in_start,
                        input bit early_drop, input bit raise_other, input int hold,
                        output int obs_own);
    int own, endj, hold_eff;
    bit tmo, err_exp;
    logic [1:0] gexp;
    own      = pick(req_drv, last_m);
    gexp     = (own == 1) ? 2'b10 : 2'b01;
    tmo      = (lat < 0) || (lat > to_cur - 1);
    endj     = tmo ? to_cur - 1 : lat;
    hold_eff = early_drop ? 0 : hold;
    cyc();
    obs_own = o_gnt[1] ? 1 : 0;
    chk("gnt", o_gnt, gexp);
    chk("busy", o_busy, 1);
    chk("start_early", o_eng_start, 0);
    if (done_in_start) begin
      eng_done_drv   = 1'b1;
      eng_result_drv = ~data;
    end
    cyc();
    eng_done_drv = 1'b0;
    chk("eng_start", o_eng_start, 1);
    if (early_drop) req_drv[own] = 1'b0;
    if (raise_other) req_drv[1-own] = 1'b1;
    for (int j = 0; j <= endj; j++) begin
      if (j == 1) chk("start_once", o_eng_start, 0);
      if (!tmo && j == lat) begin
        eng_done_drv   = 1'b1;
        eng_result_drv = data;
      end
      cyc();
      eng_done_drv = 1'b0;
    end
    if (!tmo) begin
      res_m = data;
      own_m = own;
    end
    err_exp = tmo || any_ge(res_m);
    chk("res_data", o_res_data, res_m);
    chk("res_owner", o_res_owner, own_m);
    chk("done_early", o_job_done, 0);
    cyc();
    chk("job_done", o_job_done, gexp);
    chk("job_err", o_job_err, err_exp);
    chk("gnt_check", o_gnt, gexp);
    for (int i = 0; i < hold_eff; i++) begin
      cyc();
      chk("done_pulse", o_job_done, 0);
      chk("gnt_hold", o_gnt, gexp);
      chk("err_hold", o_job_err, err_exp);
    end
    req_drv[own] = 1'b0;
    cyc();
    chk("gnt_clear", o_gnt, 0);
    chk("busy_clear", o_busy, 0);
    chk("err_keep", o_job_err, err_exp);
    last_m = own;
  endtask

  initial begin
    sel            = 1'b0;
    to_cur         = TO_A;
    req_drv        = '0;
    eng_done_drv   = 1'b0;
    eng_result_drv = '0;
    rst            = 1'b0;
    model_reset();
    cyc();
    cyc();
    chk_zero("rst_a");
    sel = 1'b1;
    #1;
    chk_zero("rst_b");
    sel = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();

    // Single request, all coefficients 5 after 40 cycles.
    req_drv = 2'b01;
    do_job(40, fill(5), 1'b0, 1'b0, 1'b0, 2, own_o);
    chk("single_owner", own_o, 0);

    // Contention from reset: grants alternate while both requests are re-raised.
    do_reset();
    req_drv = 2'b11;
    for (int i = 0; i < 4; i++) begin
      do_job(8 + i, rand_coefs(1'b0), 1'b0, 1'b0, 1'b0, 1, own_o);
      chk("rr_order", own_o, rr_exp[i]);
      req_drv = (i < 3) ? 2'b11 : 2'b00;
    end

    // Range error on coefficient 7, then the largest legal value.
    req_drv = 2'b10;
    do_job(6, coef7(97), 1'b0, 1'b0, 1'b0, 0, own_o);
    req_drv = 2'b10;
    do_job(6, coef7(96), 1'b0, 1'b0, 1'b0, 0, own_o);

    // eng_done during START is ignored; request dropped early; other side queued.
    req_drv = 2'b01;
    do_job(12, rand_coefs(1'b0), 1'b1, 1'b0, 1'b0, 1, own_o);
    req_drv = 2'b01;
    do_job(9, rand_coefs(1'b0), 1'b0, 1'b1, 1'b1, 0, own_o);
    do_job(7, rand_coefs(1'b1), 1'b0, 1'b0, 1'b0, 0, own_o);
    chk("queued_owner", own_o, 1);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      if (req_drv == '0) req_drv = 2'($urandom_range(1, 3));
      ed = ($urandom_range(0, 3) == 0);
      do_job(int'($urandom_range(1, 50)), rand_coefs($urandom_range(0, 1) == 1),
             $urandom_range(0, 3) == 0, ed, $urandom_range(0, 1) == 1,
             int'($urandom_range(0, 3)), own_o);
    end
    req_drv = '0;
    cyc();

    // Reset in the middle of WAIT.
    req_drv = 2'b01;
    repeat (7) cyc();
    rst = 1'b0;
    #1;
    chk_zero("rst_mid");
    req_drv = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_zero("rst_hold");
    end
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("no_start_after_rst", o_eng_start, 0);
      chk("no_gnt_after_rst", o_gnt, 0);
    end
    req_drv = 2'b01;
    do_job(10, fill(3), 1'b0, 1'b0, 1'b0, 0, own_o);

    // Short watchdog instance.
    sel    = 1'b1;
    to_cur = TO_B;
    do_reset();
    d1 = rand_coefs(1'b0);
    req_drv = 2'b01;
    do_job(5, d1, 1'b0, 1'b0, 1'b0, 0, own_o);
    req_drv = 2'b10;
    do_job(-1, rand_coefs(1'b0), 1'b0, 1'b0, 1'b0, 1, own_o);
    chk("tmo_res_kept", o_res_data, d1);
    d3 = rand_coefs(1'b0);
    req_drv = 2'b01;
    do_job(TO_B - 1, d3, 1'b0, 1'b0, 1'b0, 0, own_o);
    chk("expiry_latched", o_res_data, d3);
    req_drv = 2'b10;
    do_job(TO_B, rand_coefs(1'b0), 1'b0, 1'b0, 1'b0, 0, own_o);
    for (int t = 0; t < 10; t++) begin
      if (req_drv == '0) req_drv = 2'($urandom_range(1, 3));
      do_job(int'($urandom_range(1, 20)), rand_coefs($urandom_range(0, 1) == 1),
             1'b0, 1'b0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 2)), own_o);
    end
    req_drv = '0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
